core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
- Sits directly downstream of the pipeline datapath; the datapath's instruction bus and data bus both feed this block.
- Merges the two ports onto the single memory-side cache bus, one transaction in flight at a time.
- Latches the granted request, drives it onto the cache bus and holds it stable until the last response beat.
- Returns the completion (addr_ok/data_ok/data) to the granted port only.

Parameters:
- DBUS_FIXED_PRIO, 1: 1 = dbus always wins a simultaneous request; 0 = alternate grant between ports on simultaneous requests.
- CBUS_LEN, 0 (MLEN1): burst length field driven on every cache-bus request; single-beat only.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ireq  in  ibus_req_t  fetch request from datapath (valid, addr).
- iresp  out  ibus_resp_t  addr_ok, data_ok, data to fetch.
- dreq  in  dbus_req_t  memory-stage request (valid, addr, size, strobe, data).
- dresp  out  dbus_resp_t  addr_ok, data_ok, data to memory stage.
- creq  out  cbus_req_t  valid, is_write, size, addr, strobe, data, len, burst.
- cresp  in  cbus_resp_t  ready, last, data.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; creq all fields 0; iresp and dresp all 0; last_grant = IBUS.
- States: IDLE, BUSY, and a one-cycle DONE.
- IDLE:
  - Grant dbus if only dreq.valid; grant ibus if only ireq.valid.
  - If both are valid: grant dbus when DBUS_FIXED_PRIO=1; otherwise grant the port that is not last_grant.
  - On grant: latch the converted request into saved_req, record grant_sel, update last_grant, go to BUSY.
  - No output change in the grant cycle.
- Conversion from ibus: is_write=0, size=MSIZE4, strobe=0, data=0.
- Conversion from dbus: is_write = |strobe, with size, strobe and data copied unchanged.
- All conversions: len=CBUS_LEN, burst=AXI_BURST_FIXED, addr copied unchanged.
- BUSY:
  - creq = saved_req with valid=1, held constant every cycle.
  - Any change on ireq or dreq is ignored while in BUSY.
  - When cresp.ready && cresp.last, capture cresp.data and go to DONE.
  - cresp.ready without last is ignored; single-beat transactions only.
- DONE:
  - creq.valid = 0.
  - The granted port sees addr_ok=1, data_ok=1 and data = captured data for exactly this one cycle.
  - The other port's outputs stay 0. Next state is IDLE.
- Latency: the grant cycle is N and creq.valid rises at N+1. If ready&last arrives at cycle M, the ok pulse is at M+1.
- Minimum is 3 cycles from request to ok when memory answers immediately; at least one IDLE cycle separates back-to-back transactions.
- Requester contract: hold valid and fields until data_ok. The arbiter never issues a response while in IDLE or BUSY.
- Abandoned request: if the granted requester's valid is 0 in the DONE cycle (for example after a flush), the memory transaction has already completed. The ok pulse is suppressed and the data is discarded; no error is raised.
- Reset mid-transaction: state goes to IDLE and creq.valid=0 on the cycle after rst. The outstanding memory response is not tracked; the memory side is reset by the same rst.
- Writes: the data_ok pulse is produced identically, with data = cresp.data (don't-care to the memory stage).

Decomposition:
- Shared package common (existing): ibus/dbus/cbus struct types, MSIZE*, MLEN*, AXI_BURST_*.
- New package additions in common:
  - arbiter state enum ARB_STATE {IDLE, BUSY, DONE}.
  - grant enum ARB_SEL {SEL_IBUS, SEL_DBUS}.
- One natural sub-module, bus_req_convert: purely combinational conversion of ibus_req_t/dbus_req_t into cbus_req_t. The arbiter owns all state.

Test Plan:
- Lone ibus read: ireq.valid, addr 0x8000_0000; memory ready&last 2 cycles after creq.valid with data 0x0000_0013. Expect creq size=MSIZE4, is_write=0; iresp data_ok one cycle with data 0x13; dresp stays 0.
- Simultaneous requests, DBUS_FIXED_PRIO=1: ireq 0x8000_0004 and dreq write addr 0x8000_1000, strobe 0xFF, data 0xDEAD. Expect dbus served first (is_write=1), then ibus; dresp.data_ok precedes iresp.data_ok.
- Simultaneous requests, DBUS_FIXED_PRIO=0, both held for 4 transactions. Expect grant order D,I,D,I.
- Abandon: grant ibus, drop ireq.valid while BUSY. Expect creq held until ready&last, no iresp pulse, return to IDLE.
- Stability: in BUSY toggle dreq.addr every cycle. Expect creq.addr constant at the latched value.
- Reset mid-BUSY: assert rst one cycle during BUSY. Expect creq.valid=0 and all responses 0 next cycle, and a fresh request is accepted after rst deasserts.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core-to-cache arbiter: ibus/dbus/cbus structs,
// memory size/length/burst encodings and the arbiter state/grant enums.
package core_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        SEL_IBUS = 1'b0,
        SEL_DBUS = 1'b1
    } arb_sel_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        msize_t            size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        mlen_t             len;
        axi_burst_t        burst;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

    // A data-bus request is a write as soon as any byte lane is enabled.
    function automatic logic strobe_is_write(input logic [STRB_W-1:0] strobe);
        return |strobe;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_convert.sv
// Combinational translation of the selected fetch or memory-stage request
// into a single-beat cache-bus request.
module bus_req_convert
    import core_bus_arbiter_pkg::*;
#(
    parameter mlen_t CBUS_LEN = MLEN1
) (
    input  ibus_req_t i_ireq,
    input  dbus_req_t i_dreq,
    input  arb_sel_t  i_sel,
    output cbus_req_t o_creq
);

    // Build the cache-bus request for whichever port is selected.
    always_comb begin
        o_creq       = '0;
        o_creq.valid = 1'b1;
        o_creq.len   = CBUS_LEN;
        o_creq.burst = AXI_BURST_FIXED;
        case (i_sel)
            SEL_DBUS: begin
                o_creq.is_write = strobe_is_write(i_dreq.strobe);
                o_creq.size     = i_dreq.size;
                o_creq.addr     = i_dreq.addr;
                o_creq.strobe   = i_dreq.strobe;
                o_creq.data     = i_dreq.data;
            end
            SEL_IBUS: begin
                o_creq.is_write = 1'b0;
                o_creq.size     = MSIZE4;
                o_creq.addr     = i_ireq.addr;
                o_creq.strobe   = {STRB_W{1'b0}};
                o_creq.data     = {DATA_W{1'b0}};
            end
            default: begin
                o_creq.valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-port arbiter merging the fetch and memory-stage buses onto one cache
// bus, one single-beat transaction in flight, completion routed to the winner.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter logic  DBUS_FIXED_PRIO = 1'b1,
    parameter mlen_t CBUS_LEN        = MLEN1
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    arb_state_t        r_state,      w_state_nxt;
    arb_sel_t          r_grant_sel,  w_grant_sel_nxt;
    arb_sel_t          r_last_grant, w_last_grant_nxt;
    cbus_req_t         r_creq,       w_creq_nxt;
    logic [DATA_W-1:0] r_rdata,      w_rdata_nxt;
    arb_sel_t          w_sel;
    cbus_req_t         w_conv;

    bus_req_convert #(
        .CBUS_LEN(CBUS_LEN)
    ) u_convert (
        .i_ireq (ireq),
        .i_dreq (dreq),
        .i_sel  (w_sel),
        .o_creq (w_conv)
    );

    // Pick the winner among the ports requesting in this cycle.
    always_comb begin
        w_sel = SEL_IBUS;
        if (ireq.valid && dreq.valid) begin
            if (DBUS_FIXED_PRIO) begin
                w_sel = SEL_DBUS;
            end else if (r_last_grant == SEL_DBUS) begin
                w_sel = SEL_IBUS;
            end else begin
                w_sel = SEL_DBUS;
            end
        end else if (dreq.valid) begin
            w_sel = SEL_DBUS;
        end else begin
            w_sel = SEL_IBUS;
        end
    end

    // Transaction sequencing; r_creq doubles as the latched request.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_sel_nxt  = r_grant_sel;
        w_last_grant_nxt = r_last_grant;
        w_creq_nxt       = r_creq;
        w_rdata_nxt      = r_rdata;
        case (r_state)
            IDLE: begin
                if (ireq.valid || dreq.valid) begin
                    w_state_nxt      = BUSY;
                    w_grant_sel_nxt  = w_sel;
                    w_last_grant_nxt = w_sel;
                    w_creq_nxt       = w_conv;
                end else begin
                    w_creq_nxt = '0;
                end
            end
            BUSY: begin
                // Ready without last is not a completion for a single-beat request.
                if (cresp.ready && cresp.last) begin
                    w_state_nxt = DONE;
                    w_rdata_nxt = cresp.data;
                    w_creq_nxt  = '0;
                end else begin
                    w_creq_nxt = r_creq;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_creq_nxt  = '0;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant_sel  <= SEL_IBUS;
            r_last_grant <= SEL_IBUS;
            r_creq       <= '0;
            r_rdata      <= {DATA_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_grant_sel  <= w_grant_sel_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_creq       <= w_creq_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign creq = r_creq;

    // Completion pulse goes to the granted port only, and only if it still wants it.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (r_state == DONE && r_grant_sel == SEL_IBUS && ireq.valid) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = r_rdata;
        end else if (r_state == DONE && r_grant_sel == SEL_DBUS && dreq.valid) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = r_rdata;
        end else begin
            iresp = '0;
            dresp = '0;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomized self-checking bench: unit 0 uses fixed dbus priority, unit 1
// alternates; a transaction-level model predicts grants, cache requests and pulses.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    ibus_req_t  ireq  [2];
    dbus_req_t  dreq  [2];
    cbus_resp_t cresp [2];
    ibus_resp_t iresp [2];
    dbus_resp_t dresp [2];
    cbus_req_t  creq  [2];
    arb_sel_t   last_grant [2];
    int         vectors     = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    core_bus_arbiter #(.DBUS_FIXED_PRIO(1'b1), .CBUS_LEN(MLEN1)) dut_fixed (
        .clk(clk), .rst(rst), .ireq(ireq[0]), .iresp(iresp[0]),
        .dreq(dreq[0]), .dresp(dresp[0]), .creq(creq[0]), .cresp(cresp[0])
    );

    core_bus_arbiter #(.DBUS_FIXED_PRIO(1'b0), .CBUS_LEN(MLEN1)) dut_alt (
        .clk(clk), .rst(rst), .ireq(ireq[1]), .iresp(iresp[1]),
        .dreq(dreq[1]), .dresp(dresp[1]), .creq(creq[1]), .cresp(cresp[1])
    );

    function automatic arb_sel_t pick(input int u, input logic iv, input logic dv);
        if (iv && dv) begin
            if (u == 0) return SEL_DBUS;
            if (last_grant[u] == SEL_DBUS) return SEL_IBUS;
            return SEL_DBUS;
        end
        if (dv) return SEL_DBUS;
        return SEL_IBUS;
    endfunction

    function automatic cbus_req_t exp_cbus(input arb_sel_t who, input ibus_req_t ir, input dbus_req_t dr);
        cbus_req_t e;
        e       = '0;
        e.valid = 1'b1;
        e.len   = MLEN1;
        e.burst = AXI_BURST_FIXED;
        if (who == SEL_DBUS) begin
            e.is_write = (dr.strobe != 8'h00);
            e.size     = dr.size;
            e.addr     = dr.addr;
            e.strobe   = dr.strobe;
            e.data     = dr.data;
        end else begin
            e.size = MSIZE4;
            e.addr = ir.addr;
        end
        return e;
    endfunction

    // One full transaction on unit u starting in an IDLE cycle with requests already driven.
    task automatic txn(input int u, input int delay, input logic [63:0] rdata,
                       input logic abandon, input logic toggle, output int obs);
        arb_sel_t   w;
        cbus_req_t  e;
        ibus_resp_t ei;
        dbus_resp_t ed;
        obs = 0;
        w = pick(u, ireq[u].valid, dreq[u].valid);
        last_grant[u] = w;
        e = exp_cbus(w, ireq[u], dreq[u]);
        vectors++;
        if (creq[u].valid !== 1'b0 || iresp[u] !== '0 || dresp[u] !== '0) begin
            miscompares++;
            $display("FAIL grant_cycle_quiet u%0d: creq.valid=%b iresp=%h dresp=%h, required all 0",
                     u, creq[u].valid, iresp[u], dresp[u]);
        end
        @(negedge clk);
        vectors++;
        if (creq[u] !== e) begin
            miscompares++;
            $display("FAIL creq_issue u%0d: got %h, required %h", u, creq[u], e);
        end
        if (abandon) begin
            ireq[u].valid = 1'b0;
            dreq[u].valid = 1'b0;
        end
        for (int k = 0; k < delay; k++) begin
            cresp[u].ready = 1'($urandom_range(0, 1));
            cresp[u].last  = 1'b0;
            cresp[u].data  = {$urandom, $urandom};
            if (toggle) begin
                dreq[u].addr = $urandom;
                ireq[u].addr = $urandom;
            end
            @(negedge clk);
            vectors++;
            if (creq[u] !== e || iresp[u] !== '0 || dresp[u] !== '0) begin
                miscompares++;
                $display("FAIL busy_hold u%0d: creq=%h iresp=%h dresp=%h, required creq=%h and no response",
                         u, creq[u], iresp[u], dresp[u], e);
            end
        end
        cresp[u].ready = 1'b1;
        cresp[u].last  = 1'b1;
        cresp[u].data  = rdata;
        @(negedge clk);
        cresp[u] = '0;
        ei = '0;
        ed = '0;
        if (w == SEL_IBUS && ireq[u].valid) begin
            ei.addr_ok = 1'b1; ei.data_ok = 1'b1; ei.data = rdata;
        end
        if (w == SEL_DBUS && dreq[u].valid) begin
            ed.addr_ok = 1'b1; ed.data_ok = 1'b1; ed.data = rdata;
        end
        vectors++;
        if (creq[u].valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_creq_valid u%0d: got %b, required 0", u, creq[u].valid);
        end
        vectors++;
        if (iresp[u] !== ei) begin
            miscompares++;
            $display("FAIL done_iresp u%0d: got %h, required %h", u, iresp[u], ei);
        end
        vectors++;
        if (dresp[u] !== ed) begin
            miscompares++;
            $display("FAIL done_dresp u%0d: got %h, required %h", u, dresp[u], ed);
        end
        if (iresp[u].data_ok === 1'b1) obs = 1;
        else if (dresp[u].data_ok === 1'b1) obs = 2;
        if (w == SEL_IBUS) ireq[u].valid = 1'b0;
        else dreq[u].valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (iresp[u] !== '0 || dresp[u] !== '0 || creq[u].valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done u%0d: creq.valid=%b iresp=%h dresp=%h, required all 0",
                     u, creq[u].valid, iresp[u], dresp[u]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ireq[0].valid = 1'b1; ireq[0].addr = $urandom;
        dreq[1].valid = 1'b1; dreq[1].addr = $urandom;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (creq[u] !== '0 || iresp[u] !== '0 || dresp[u] !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs u%0d: creq=%h iresp=%h dresp=%h, required all 0",
                         u, creq[u], iresp[u], dresp[u]);
            end
        end
        ireq[0] = '0;
        dreq[1] = '0;
        rst = 1'b0;
        last_grant[0] = SEL_IBUS;
        last_grant[1] = SEL_IBUS;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (creq[u] !== '0 || iresp[u] !== '0 || dresp[u] !== '0) begin
                miscompares++;
                $display("FAIL post_reset_idle u%0d: creq=%h iresp=%h dresp=%h, required all 0",
                         u, creq[u], iresp[u], dresp[u]);
            end
        end
    endtask

    task automatic test_lone_ibus();
        int obs;
        ireq[0].valid = 1'b1;
        ireq[0].addr  = 32'h8000_0000;
        txn(0, 2, 64'h0000_0000_0000_0013, 1'b0, 1'b0, obs);
        vectors++;
        if (obs != 1) begin
            miscompares++;
            $display("FAIL lone_ibus_port: pulse on port code %0d, required 1 (ibus)", obs);
        end
    endtask

    task automatic test_fixed_prio();
        int obs1, obs2;
        ireq[0].valid  = 1'b1;
        ireq[0].addr   = 32'h8000_0004;
        dreq[0].valid  = 1'b1;
        dreq[0].addr   = 32'h8000_1000;
        dreq[0].size   = MSIZE8;
        dreq[0].strobe = 8'hFF;
        dreq[0].data   = 64'h0000_0000_0000_DEAD;
        txn(0, 1, {$urandom, $urandom}, 1'b0, 1'b0, obs1);
        txn(0, 0, {$urandom, $urandom}, 1'b0, 1'b0, obs2);
        vectors++;
        if (obs1 != 2 || obs2 != 1) begin
            miscompares++;
            $display("FAIL fixed_prio_order: got %0d then %0d, required 2 (dbus) then 1 (ibus)", obs1, obs2);
        end
    endtask

    task automatic test_alternate();
        int obs;
        int want [4];
        want[0] = 2; want[1] = 1; want[2] = 2; want[3] = 1;
        ireq[1].valid  = 1'b1;
        ireq[1].addr   = 32'h8000_0100;
        dreq[1].valid  = 1'b1;
        dreq[1].addr   = 32'h8000_2000;
        dreq[1].size   = MSIZE4;
        dreq[1].strobe = 8'h00;
        dreq[1].data   = 64'h0;
        for (int t = 0; t < 4; t++) begin
            txn(1, t, {$urandom, $urandom}, 1'b0, 1'b0, obs);
            vectors++;
            if (obs != want[t]) begin
                miscompares++;
                $display("FAIL alternate_order t%0d: got port code %0d, required %0d", t, obs, want[t]);
            end
            ireq[1].valid = 1'b1;
            dreq[1].valid = 1'b1;
        end
        ireq[1].valid = 1'b0;
        dreq[1].valid = 1'b0;
    endtask

    task automatic test_abandon();
        int obs;
        ireq[0].valid = 1'b1;
        ireq[0].addr  = 32'h8000_0040;
        txn(0, 3, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, obs);
        vectors++;
        if (obs != 0) begin
            miscompares++;
            $display("FAIL abandon_no_pulse: got port code %0d, required 0", obs);
        end
    endtask

    task automatic test_stability();
        int obs;
        dreq[0].valid  = 1'b1;
        dreq[0].addr   = 32'h8000_3008;
        dreq[0].size   = MSIZE2;
        dreq[0].strobe = 8'h00;
        dreq[0].data   = 64'h0;
        txn(0, 4, {$urandom, $urandom}, 1'b0, 1'b1, obs);
    endtask

    task automatic test_reset_mid_busy();
        int obs;
        ireq[0].valid = 1'b1;
        ireq[0].addr  = 32'h8000_0080;
        @(negedge clk);
        vectors++;
        if (creq[0].valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy_issue: creq.valid=%b, required 1", creq[0].valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_grant[0] = SEL_IBUS;
        last_grant[1] = SEL_IBUS;
        vectors++;
        if (creq[0] !== '0 || iresp[0] !== '0 || dresp[0] !== '0) begin
            miscompares++;
            $display("FAIL mid_busy_reset: creq=%h iresp=%h dresp=%h, required all 0",
                     creq[0], iresp[0], dresp[0]);
        end
        ireq[0].addr = 32'h8000_00C0;
        txn(0, 1, 64'hCAFE_F00D_0000_0001, 1'b0, 1'b0, obs);
    endtask

    task automatic test_random(input int u, input int n);
        int obs;
        for (int t = 0; t < n; t++) begin
            if (!ireq[u].valid && $urandom_range(0, 1) == 1) begin
                ireq[u].valid = 1'b1;
                ireq[u].addr  = $urandom;
            end
            if (!dreq[u].valid && $urandom_range(0, 1) == 1) begin
                dreq[u].valid  = 1'b1;
                dreq[u].addr   = $urandom;
                dreq[u].size   = msize_t'($urandom_range(0, 3));
                dreq[u].strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
                dreq[u].data   = {$urandom, $urandom};
            end
            if (!ireq[u].valid && !dreq[u].valid) begin
                ireq[u].valid = 1'b1;
                ireq[u].addr  = $urandom;
            end
            txn(u, $urandom_range(0, 3), {$urandom, $urandom},
                ($urandom_range(0, 7) == 0), 1'b0, obs);
        end
        ireq[u].valid = 1'b0;
        dreq[u].valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ireq[u]  = '0;
            dreq[u]  = '0;
            cresp[u] = '0;
            last_grant[u] = SEL_IBUS;
        end
        @(negedge clk);
        test_reset();
        test_lone_ibus();
        test_fixed_prio();
        test_alternate();
        test_abandon();
        test_stability();
        test_reset_mid_busy();
        test_random(0, 24);
        test_random(1, 24);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
